// File: rtl/iguana_hyper_cfg_regs.sv
// HyperBus PHY timing configuration registers on the Cheshire regbus.
// Optional write-lock feature: define IGUANA_HYPER_CFG_LOCK_EN.

package iguana_hyper_cfg_pkg;
    typedef struct packed {
        logic [47:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module iguana_hyper_cfg_regs #(
    parameter int unsigned AddrWidth = 48,
    parameter type reg_req_t = iguana_hyper_cfg_pkg::reg_req_t,
    parameter type reg_rsp_t = iguana_hyper_cfg_pkg::reg_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  reg_req_t    reg_req_i,
    output reg_rsp_t    reg_rsp_o,
    input  logic        phy_idle_i,
    output logic [3:0]  t_latency_access_o,
    output logic        en_latency_additional_o,
    output logic [15:0] t_burst_max_o,
    output logic [3:0]  t_read_write_recovery_o,
    output logic [3:0]  t_rx_clk_delay_o,
    output logic [3:0]  t_tx_clk_delay_o,
    output logic        cfg_update_o
);

    localparam logic [3:0]  RstLat   = 4'd6;
    localparam logic [15:0] RstBurst = 16'd350;
    localparam logic [3:0]  RstRwr   = 4'd6;
    localparam logic [3:0]  RstClkDl = 4'd8;

    typedef enum logic {StIdle, StResp} acc_state_e;

    acc_state_e  state_q, state_d;
    logic [2:0]  addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic [3:0]  lat_q, lat_d, act_lat_q;
    logic        addl_q, addl_d, act_addl_q;
    logic [15:0] burst_q, burst_d, act_burst_q;
    logic [3:0]  rwr_q, rwr_d, act_rwr_q;
    logic [3:0]  rx_q, rx_d, act_rx_q;
    logic [3:0]  tx_q, tx_d, act_tx_q;
    logic        pending_q, pending_d;
    logic        cfg_update_q;
    logic        lock;

    logic [AddrWidth-1:0] req_addr;
    logic [2:0]           req_idx;
    logic [31:0]          reg_view [8];
    logic [31:0]          wr_val;
    logic                 wr_en;
    logic                 commit;
    logic                 unused_bits;

    assign req_addr    = reg_req_i.addr;
    assign req_idx     = req_addr[4:2];
    assign unused_bits = ^{req_addr[AddrWidth-1:5], req_addr[1:0], wr_val[31:16]};

    assign reg_view[0] = {28'b0, lat_q};
    assign reg_view[1] = {31'b0, addl_q};
    assign reg_view[2] = {16'b0, burst_q};
    assign reg_view[3] = {28'b0, rwr_q};
    assign reg_view[4] = {28'b0, rx_q};
    assign reg_view[5] = {28'b0, tx_q};
    assign reg_view[6] = {31'b0, pending_q};
    assign reg_view[7] = {30'b0, lock, pending_q};

    // Write data merged bytewise over the current shadow contents of the target.
    always_comb begin
        wr_val = reg_view[addr_q];
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) wr_val[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    assign wr_en  = (state_q == StResp) && write_q && !error_q;
    assign commit = pending_q && phy_idle_i;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        error_d = error_q;
        unique case (state_q)
            StIdle: begin
                if (reg_req_i.valid) begin
                    state_d = StResp;
                    rdata_d = reg_view[req_idx];
                    error_d = lock && reg_req_i.write && (req_idx != 3'd7);
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        lat_d     = lat_q;
        addl_d    = addl_q;
        burst_d   = burst_q;
        rwr_d     = rwr_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        pending_d = pending_q;
        if (commit) pending_d = 1'b0;
        if (wr_en) begin
            unique case (addr_q)
                3'd0: lat_d   = wr_val[3:0];
                3'd1: addl_d  = wr_val[0];
                3'd2: burst_d = wr_val[15:0];
                3'd3: rwr_d   = wr_val[3:0];
                3'd4: rx_d    = wr_val[3:0];
                3'd5: tx_d    = wr_val[3:0];
                // A commit request landing on a transfer edge re-arms for a second commit.
                3'd6: if (wr_val[0]) pending_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            addr_q       <= 3'd0;
            write_q      <= 1'b0;
            wdata_q      <= 32'd0;
            wstrb_q      <= 4'd0;
            rdata_q      <= 32'd0;
            error_q      <= 1'b0;
            lat_q        <= RstLat;
            addl_q       <= 1'b0;
            burst_q      <= RstBurst;
            rwr_q        <= RstRwr;
            rx_q         <= RstClkDl;
            tx_q         <= RstClkDl;
            act_lat_q    <= RstLat;
            act_addl_q   <= 1'b0;
            act_burst_q  <= RstBurst;
            act_rwr_q    <= RstRwr;
            act_rx_q     <= RstClkDl;
            act_tx_q     <= RstClkDl;
            pending_q    <= 1'b0;
            cfg_update_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            if (state_q == StIdle && reg_req_i.valid) begin
                addr_q  <= req_idx;
                write_q <= reg_req_i.write;
                wdata_q <= reg_req_i.wdata;
                wstrb_q <= reg_req_i.wstrb;
            end
            lat_q     <= lat_d;
            addl_q    <= addl_d;
            burst_q   <= burst_d;
            rwr_q     <= rwr_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            pending_q <= pending_d;
            // Copies pre-write shadow values when a shadow write shares the edge.
            if (commit) begin
                act_lat_q   <= lat_q;
                act_addl_q  <= addl_q;
                act_burst_q <= burst_q;
                act_rwr_q   <= rwr_q;
                act_rx_q    <= rx_q;
                act_tx_q    <= tx_q;
            end
            cfg_update_q <= commit;
        end
    end

`ifdef IGUANA_HYPER_CFG_LOCK_EN
    logic lock_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
        end else if (wr_en && addr_q == 3'd7 && wr_val[1]) begin
            lock_q <= 1'b1;
        end
    end
    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = (state_q == StResp);
        reg_rsp_o.rdata = rdata_q;
        reg_rsp_o.error = error_q;
    end

    assign t_latency_access_o      = act_lat_q;
    assign en_latency_additional_o = act_addl_q;
    assign t_burst_max_o           = act_burst_q;
    assign t_read_write_recovery_o = act_rwr_q;
    assign t_rx_clk_delay_o        = act_rx_q;
    assign t_tx_clk_delay_o        = act_tx_q;
    assign cfg_update_o            = cfg_update_q;

endmodule

// File: tb/tb_iguana_hyper_cfg_regs.sv
// Directed bench for iguana_hyper_cfg_regs: scoreboarded regbus accesses plus commit timing checks.
module tb_iguana_hyper_cfg_regs;
    import iguana_hyper_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    reg_req_t    req;
    reg_rsp_t    rsp;
    logic        phy_idle;
    logic [3:0]  t_lat;
    logic        en_addl;
    logic [15:0] t_burst;
    logic [3:0]  t_rwr;
    logic [3:0]  t_rx;
    logic [3:0]  t_tx;
    logic        cfg_update;

    iguana_hyper_cfg_regs dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_ni),
        .reg_req_i               (req),
        .reg_rsp_o               (rsp),
        .phy_idle_i              (phy_idle),
        .t_latency_access_o      (t_lat),
        .en_latency_additional_o (en_addl),
        .t_burst_max_o           (t_burst),
        .t_read_write_recovery_o (t_rwr),
        .t_rx_clk_delay_o        (t_rx),
        .t_tx_clk_delay_o        (t_tx),
        .cfg_update_o            (cfg_update)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        chk_rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Drives a request at the current negedge; returns at the negedge where ready is seen,
    // with valid still asserted so the caller may chain another access.
    task automatic access(input string tag, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input logic chk_rd, output int n);
        exp_t e;
        bit   got;
        exp_q.push_back('{rdata: exp_rd, error: exp_err, chk_rd: chk_rd});
        req.addr  = {16'h0, 32'h8000_0000 + addr};
        req.write = wr;
        req.wdata = wdata;
        req.wstrb = strb;
        req.valid = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (rsp.ready === 1'b1) got = 1'b1;
        end
        e = exp_q.pop_front();
        checks++;
        assert (got) else begin
            failures++;
            $error("FAIL %s/timeout: observed=no ready expected=ready within 10 cycles", tag);
        end
        if (got) begin
            check({tag, "/error"}, {31'b0, rsp.error}, {31'b0, e.error});
            if (e.chk_rd) check({tag, "/rdata"}, rsp.rdata, e.rdata);
        end
    endtask

    task automatic bus_idle();
        req.valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] expv);
        int n;
        access(tag, addr, 1'b0, 32'h0, 4'h0, expv, 1'b0, 1'b1, n);
        bus_idle();
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic exp_err);
        int n;
        access(tag, addr, 1'b1, data, strb, 32'h0, exp_err, 1'b0, n);
        bus_idle();
    endtask

    initial begin
        req      = '0;
        phy_idle = 1'b0;
        rst_ni   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_lat", {28'b0, t_lat}, 32'd6);
        check("rst_addl", {31'b0, en_addl}, 32'd0);
        check("rst_burst", {16'b0, t_burst}, 32'd350);
        check("rst_rwr", {28'b0, t_rwr}, 32'd6);
        check("rst_rx", {28'b0, t_rx}, 32'd8);
        check("rst_tx", {28'b0, t_tx}, 32'd8);
        check("rst_upd", {31'b0, cfg_update}, 32'd0);
        check("rst_ready", {31'b0, rsp.ready}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);

        // Latency: first access from idle, then two chained accesses.
        access("rd00", 32'h00, 1'b0, 32'h0, 4'h0, 32'd6, 1'b0, 1'b1, lat);
        check("lat_first", lat, 32'd1);
        access("rd08", 32'h08, 1'b0, 32'h0, 4'h0, 32'd350, 1'b0, 1'b1, lat);
        check("lat_b2b", lat, 32'd2);
        access("rd10", 32'h10, 1'b0, 32'h0, 4'h0, 32'd8, 1'b0, 1'b1, lat);
        check("lat_b2b2", lat, 32'd2);
        bus_idle();
        rd("rd04", 32'h04, 32'd0);
        rd("rd0c", 32'h0C, 32'd6);
        rd("rd14", 32'h14, 32'd8);
        rd("rd18", 32'h18, 32'd0);
        rd("rd1c", 32'h1C, 32'd0);
        rd("rd01_lowbits", 32'h01, 32'd6);

        // Commit gated by PHY idle.
        wr("wr00", 32'h00, 32'hA, 4'hF, 1'b0);
        wr("commit1", 32'h18, 32'h1, 4'hF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("gate_lat", {28'b0, t_lat}, 32'd6);
        end
        rd("status_pend", 32'h1C, 32'd1);
        rd("shadow00", 32'h00, 32'hA);
        phy_idle = 1'b1;
        @(negedge clk);
        check("commit_lat", {28'b0, t_lat}, 32'hA);
        check("commit_upd", {31'b0, cfg_update}, 32'd1);
        phy_idle = 1'b0;
        @(negedge clk);
        check("commit_upd_end", {31'b0, cfg_update}, 32'd0);
        rd("status_clear", 32'h1C, 32'd0);

        // Strobes and truncation.
        wr("wr08_strb", 32'h08, 32'hFFFF_1234, 4'b0001, 1'b0);
        rd("rd08_strb", 32'h08, 32'h0134);
        wr("wr00_trunc", 32'h00, 32'hFFFF_FFF3, 4'hF, 1'b0);
        rd("rd00_trunc", 32'h00, 32'd3);
        wr("wr0c_nostrb", 32'h0C, 32'hFFFF_FFFF, 4'h0, 1'b0);
        rd("rd0c_nostrb", 32'h0C, 32'd6);
        wr("commit2", 32'h18, 32'h1, 4'h1, 1'b0);
        phy_idle = 1'b1;
        @(negedge clk);
        check("strb_burst", {16'b0, t_burst}, 32'h0134);
        check("trunc_lat", {28'b0, t_lat}, 32'd3);
        check("nostrb_rwr", {28'b0, t_rwr}, 32'd6);
        phy_idle = 1'b0;
        @(negedge clk);

        // Shadow write on the transfer edge: active keeps the pre-write value.
        wr("commit3", 32'h18, 32'h1, 4'hF, 1'b0);
        access("race_wr10", 32'h10, 1'b1, 32'h3, 4'hF, 32'h0, 1'b0, 1'b0, lat);
        phy_idle = 1'b1;
        bus_idle();
        check("race_upd", {31'b0, cfg_update}, 32'd1);
        check("race_active", {28'b0, t_rx}, 32'd8);
        rd("race_shadow", 32'h10, 32'd3);
        check("race_active_hold", {28'b0, t_rx}, 32'd8);
        phy_idle = 1'b0;

        // Commit write on the transfer edge: a second commit follows.
        wr("commit4", 32'h18, 32'h1, 4'hF, 1'b0);
        access("commit5", 32'h18, 1'b1, 32'h1, 4'hF, 32'h0, 1'b0, 1'b0, lat);
        phy_idle = 1'b1;
        bus_idle();
        check("dbl_upd1", {31'b0, cfg_update}, 32'd1);
        check("dbl_rx", {28'b0, t_rx}, 32'd3);
        @(negedge clk);
        check("dbl_upd2", {31'b0, cfg_update}, 32'd1);
        @(negedge clk);
        check("dbl_upd_end", {31'b0, cfg_update}, 32'd0);
        phy_idle = 1'b0;
        rd("dbl_status", 32'h1C, 32'd0);

`ifdef IGUANA_HYPER_CFG_LOCK_EN
        wr("lock_set", 32'h1C, 32'h2, 4'hF, 1'b0);
        rd("lock_status", 32'h1C, 32'd2);
        wr("lock_wr00", 32'h00, 32'h1, 4'hF, 1'b1);
        rd("lock_rd00", 32'h00, 32'd3);
        wr("lock_commit", 32'h18, 32'h1, 4'hF, 1'b1);
        rd("lock_status2", 32'h1C, 32'd2);
`else
        wr("nolock_set", 32'h1C, 32'h2, 4'hF, 1'b0);
        rd("nolock_status", 32'h1C, 32'd0);
        wr("nolock_wr00", 32'h00, 32'h3, 4'hF, 1'b0);
`endif

        // Asynchronous reset in the middle of a response.
        access("rst_mid", 32'h00, 1'b0, 32'h0, 4'h0, 32'd3, 1'b0, 1'b1, lat);
        rst_ni = 1'b0;
        #1;
        check("arst_ready", {31'b0, rsp.ready}, 32'd0);
        check("arst_lat", {28'b0, t_lat}, 32'd6);
        check("arst_upd", {31'b0, cfg_update}, 32'd0);
        req.valid = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        rd("arst_rd00", 32'h00, 32'd6);
        rd("arst_status", 32'h1C, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
